sr04_dist_filter: RTL and testbench
===================================

Name: sr04_dist_filter

Overview:
Downstream consumer of the SR04 controller's distance output. It takes each completed measurement (dist, dist_done) and rejects out-of-range samples. Valid samples go into a 2^N_LOG2-deep moving-average window. Once the window is full, the block emits a smoothed distance with a one-cycle valid strobe and a hysteretic "near" flag for the display/alarm logic.

Parameters:
N_LOG2, 2, log2 of window depth (window = 4 samples by default)
MAX_DIST, 400, largest accepted distance in cm; samples above this are rejected
NEAR_ON, 20, near asserts when the average is less than or equal to this value (cm)
NEAR_OFF, 25, near deasserts when the average is greater than or equal to this value (cm); must be greater than NEAR_ON

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  synchronous reset, active-high
dist_in  in  10  distance in cm from the SR04 controller
dist_done  in  1  one-cycle strobe; dist_in is valid in that cycle
avg_dist  out  10  filtered distance, floor(sum / 2^N_LOG2)
avg_valid  out  1  one-cycle strobe; avg_dist and near are updated in that cycle
near  out  1  proximity flag with hysteresis
filled  out  1  high once 2^N_LOG2 samples have been accepted
drop_cnt  out  8  saturating count of rejected samples

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - avg_dist=0, avg_valid=0, near=0, filled=0, drop_cnt=0.
  - All window entries=0, running sum=0, write pointer=0, fill count=0.
  - Pipeline valid flags=0.
- Reset mid-operation: any sample in flight is discarded, and no avg_valid is produced for it.
- Accept rule: a sample is accepted when dist_done=1 and 1 <= dist_in <= MAX_DIST.
- Reject rule:
  - Applies when dist_in=0 or dist_in>MAX_DIST.
  - drop_cnt increments by 1 and saturates at 255.
  - Window, sum, pointer, fill count and outputs are unchanged; no avg_valid.
- dist_in is ignored when dist_done=0.
- Pipeline: dist_done is sampled at clock edge T.
  - Edge T, stage 0: register the sample and the accept flag.
  - Edge T+1, stage 1:
    - sum <= sum - win[wr_ptr] + sample; win[wr_ptr] <= sample.
    - wr_ptr increments modulo 2^N_LOG2 (natural wrap).
    - Fill count increments and saturates at 2^N_LOG2.
  - Edge T+2, stage 2: if the window is full (including when this sample fills it):
    - avg_dist <= sum[N_LOG2+9:N_LOG2] (truncating divide).
    - avg_valid <= 1 for exactly one cycle.
    - near is updated.
  - Latency is 2 cycles from the dist_done edge to avg_valid.
- Throughput: fully pipelined, one sample per cycle. Back-to-back dist_done strobes produce back-to-back avg_valid strobes.
- Before the window is full: accepted samples update the window/sum, but avg_valid stays 0 and avg_dist holds.
- Sum width: 10+N_LOG2 bits; cannot overflow because every entry is at most 1023.
- filled: goes high in the same cycle as the first avg_valid and stays high until rst.
- FSM (2 states):
  - FILL: fill count < 2^N_LOG2; outputs suppressed. Moves to RUN when the 2^N_LOG2-th accepted sample reaches stage 2.
  - RUN: every accepted sample yields avg_valid. Leaves RUN only on rst.
- Near hysteresis: evaluated only in a cycle where avg_valid is produced, using the new average.
  - near <= 1 if avg <= NEAR_ON.
  - near <= 0 if avg >= NEAR_OFF.
  - Otherwise near holds.
- Outputs are not updated by rejected samples.
- Simultaneous events:
  - rst has priority over dist_done.
  - A reject can occur in the same cycle an earlier accepted sample is in stage 1 or 2; both take effect independently.

Test Plan:
1. Fill: rst, then accepted samples 100,100,100,100 spaced 10 cycles apart -> no avg_valid for the first three; on the 4th, avg_valid pulses 2 cycles after dist_done with avg_dist=100, filled=1, near=0.
2. Wrap-around: continue from scenario 1 with 200,200,200,200 -> avg_dist sequence 125,150,175,200, each with a single-cycle avg_valid.
3. Rejection: dist_in=0, then 500, then 400 (window of 200s) -> drop_cnt=2 with no avg_valid for the first two; 400 accepted with avg_dist=250. Then 300 further rejects -> drop_cnt=255.
4. Hysteresis: window 30,30,30,30 (avg 30, near=0), then add 10,10,40,40 -> avgs 25 (near 0), 20 (near 1), 22 (near holds 1), 25 (near 0).
5. Back-to-back: dist_done held high for 8 consecutive cycles with dist_in=50 after rst -> avg_valid high on 5 consecutive cycles starting 2 cycles after the 4th strobe, avg_dist=50 each.
6. Reset mid-operation: accepted dist_done at edge T, rst=1 at edge T+1 -> no avg_valid at T+2; filled=0, drop_cnt=0, near=0. A subsequent fill of four 80s yields avg_dist=80.

Source files
------------

// File: rtl/sr04_dist_filter.sv
// ---------------------------------------------------------------------------
// sr04_dist_filter
//
// Post-processing for SR04 distance measurements. Each completed measurement
// (dist_in qualified by the one-cycle dist_done strobe) is range-checked.
// Out-of-range samples are counted and otherwise ignored. In-range samples go
// into a 2^N_LOG2-deep moving-average window. Once the window has been filled,
// every accepted sample produces a smoothed distance with a one-cycle valid
// strobe and a hysteretic proximity flag.
//
// Pipeline (dist_done sampled at edge T):
//   T   stage 0 : register sample + accept flag, count rejects
//   T+1 stage 1 : window write, running-sum update, pointer/fill advance
//   T+2 stage 2 : average, near flag, avg_valid strobe (only when full)
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous reset, active-high
//   dist_in    in   [9:0] distance in cm, valid while dist_done=1
//   dist_done  in   one-cycle measurement strobe
//   avg_dist   out  [9:0] floor(window sum / 2^N_LOG2)
//   avg_valid  out  one-cycle strobe; avg_dist and near updated this cycle
//   near       out  proximity flag with hysteresis (NEAR_ON / NEAR_OFF)
//   filled     out  high once the window has been filled, until rst
//   drop_cnt   out  [7:0] saturating count of rejected samples
//   dbg_state  out  filter FSM state (0 = FILL, 1 = RUN)
//
// Handshake: dist_done is a valid-only strobe with no backpressure; one sample
// per cycle is accepted. avg_valid is likewise a valid-only strobe; consumers
// must take avg_dist/near in the cycle avg_valid is high.
// ---------------------------------------------------------------------------
module sr04_dist_filter #(
  parameter int N_LOG2   = 2,
  parameter int MAX_DIST = 400,
  parameter int NEAR_ON  = 20,
  parameter int NEAR_OFF = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] dist_in,
  input  logic       dist_done,
  output logic [9:0] avg_dist,
  output logic       avg_valid,
  output logic       near,
  output logic       filled,
  output logic [7:0] drop_cnt,
  output logic       dbg_state
);

  localparam int DEPTH = 1 << N_LOG2;
  localparam int SUM_W = 10 + N_LOG2;
  localparam int CNT_W = N_LOG2 + 1;

  localparam logic ST_FILL = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  // stage 0
  logic             s0_vld_q, s0_vld_d;
  logic [9:0]       s0_data_q, s0_data_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  // stage 1
  logic [9:0]       win_q [DEPTH];
  logic [9:0]       win_d [DEPTH];
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [N_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
  logic             s1_vld_q, s1_vld_d;

  // stage 2
  logic             state_q, state_d;
  logic [9:0]       avg_q, avg_d;
  logic             avg_valid_q, avg_valid_d;
  logic             near_q, near_d;

  logic             accept;
  logic             reject;
  logic             emit;
  logic [9:0]       new_avg;

  // ---------------- stage 0: range check ----------------
  always_comb begin
    accept = dist_done && (dist_in != 10'd0) && (dist_in <= 10'(MAX_DIST));
    reject = dist_done && !accept;

    s0_vld_d  = accept;
    s0_data_d = accept ? dist_in : s0_data_q;

    drop_cnt_d = drop_cnt_q;
    if (reject && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // ---------------- stage 1: window / running sum ----------------
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      win_d[i] = win_q[i];
    end
    sum_d      = sum_q;
    wr_ptr_d   = wr_ptr_q;
    fill_cnt_d = fill_cnt_q;
    s1_vld_d   = s0_vld_q;

    if (s0_vld_q) begin
      // The slot being overwritten is the oldest sample (or 0 while filling),
      // so the sum always equals the sum of the window contents. Intermediate
      // wrap in the subtraction cancels out because the result fits.
      sum_d           = sum_q - SUM_W'(win_q[wr_ptr_q]) + SUM_W'(s0_data_q);
      win_d[wr_ptr_q] = s0_data_q;
      wr_ptr_d        = wr_ptr_q + N_LOG2'(1);
      if (fill_cnt_q != CNT_W'(DEPTH)) begin
        fill_cnt_d = fill_cnt_q + CNT_W'(1);
      end
    end
  end

  // ---------------- stage 2: average, near, FSM ----------------
  always_comb begin
    // fill_cnt_q already includes the sample now in stage 2, so a full count
    // here also covers the sample that completes the window.
    emit    = s1_vld_q && (fill_cnt_q == CNT_W'(DEPTH));
    new_avg = sum_q[N_LOG2+9:N_LOG2];

    avg_valid_d = emit;
    avg_d       = avg_q;
    near_d      = near_q;
    state_d     = state_q;

    if (emit) begin
      avg_d = new_avg;
      if (new_avg <= 10'(NEAR_ON)) begin
        near_d = 1'b1;
      end else if (new_avg >= 10'(NEAR_OFF)) begin
        near_d = 1'b0;
      end
    end

    case (state_q)
      ST_FILL: if (emit) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_FILL;
    endcase
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_vld_q    <= 1'b0;
      s0_data_q   <= '0;
      drop_cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        win_q[i] <= '0;
      end
      sum_q       <= '0;
      wr_ptr_q    <= '0;
      fill_cnt_q  <= '0;
      s1_vld_q    <= 1'b0;
      state_q     <= ST_FILL;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      near_q      <= 1'b0;
    end else begin
      s0_vld_q    <= s0_vld_d;
      s0_data_q   <= s0_data_d;
      drop_cnt_q  <= drop_cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        win_q[i] <= win_d[i];
      end
      sum_q       <= sum_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_cnt_q  <= fill_cnt_d;
      s1_vld_q    <= s1_vld_d;
      state_q     <= state_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      near_q      <= near_d;
    end
  end

  assign avg_dist  = avg_q;
  assign avg_valid = avg_valid_q;
  assign near      = near_q;
  assign filled    = (state_q == ST_RUN);
  assign drop_cnt  = drop_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sr04_dist_filter.sv
// ---------------------------------------------------------------------------
// tb_sr04_dist_filter
//
// Self-checking bench for sr04_dist_filter with default parameters.
// The reference model keeps the last four accepted samples in a queue and
// derives average / near / drop count directly from the filter rules. Each
// expected output (average, near, cycle it must appear) is pushed when the
// sample is issued; a monitor pops and compares whenever avg_valid is seen.
// ---------------------------------------------------------------------------
module tb_sr04_dist_filter;

  localparam int DEPTH    = 4;
  localparam int MAX_D    = 400;
  localparam int NEAR_ON  = 20;
  localparam int NEAR_OFF = 25;

  logic       clk;
  logic       rst;
  logic [9:0] dist_in;
  logic       dist_done;
  logic [9:0] avg_dist;
  logic       avg_valid;
  logic       near;
  logic       filled;
  logic [7:0] drop_cnt;
  logic       dbg_state;

  sr04_dist_filter dut (
    .clk       (clk),
    .rst       (rst),
    .dist_in   (dist_in),
    .dist_done (dist_done),
    .avg_dist  (avg_dist),
    .avg_valid (avg_valid),
    .near      (near),
    .filled    (filled),
    .drop_cnt  (drop_cnt),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [9:0] exp_q[$];
  logic       exp_near_q[$];
  int         exp_cyc_q[$];

  int checks = 0;
  int errors = 0;

  // reference model
  int mwin[$];
  int mdrop   = 0;
  bit mnear   = 0;
  bit mfilled = 0;
  int mavg    = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mwin.delete();
    mdrop   = 0;
    mnear   = 0;
    mfilled = 0;
    mavg    = 0;
  endtask

  task automatic model_sample(input int d, input int issue_cyc);
    int s;
    if (d == 0 || d > MAX_D) begin
      if (mdrop < 255) mdrop++;
    end else begin
      mwin.push_back(d);
      if (mwin.size() > DEPTH) void'(mwin.pop_front());
      if (mwin.size() == DEPTH) begin
        s = 0;
        foreach (mwin[i]) s += mwin[i];
        mavg = s / DEPTH;
        if (mavg <= NEAR_ON) mnear = 1;
        else if (mavg >= NEAR_OFF) mnear = 0;
        mfilled = 1;
        exp_q.push_back(10'(mavg));
        exp_near_q.push_back(mnear);
        exp_cyc_q.push_back(issue_cyc + 3);
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (avg_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_avg_valid: got avg_valid=1 avg=%0d expected no strobe (cycle %0d)",
                 avg_dist, cyc);
      end else begin
        check("avg_dist", int'(avg_dist), int'(exp_q.pop_front()));
        check("near", int'(near), int'(exp_near_q.pop_front()));
        check("avg_cycle", cyc, exp_cyc_q.pop_front());
        check("filled_on_valid", int'(filled), 1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input bit v, input int d);
    @(posedge clk);
    #1;
    dist_done = v;
    dist_in   = 10'(d);
    if (v) model_sample(d, cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, $urandom_range(0, 1023));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    dist_done = 1'b0;
    dist_in   = '0;
    // Results due at or before this cycle are already on the outputs; later
    // ones are killed by the reset.
    while (exp_cyc_q.size() > 0 && exp_cyc_q[exp_cyc_q.size()-1] > cyc) begin
      void'(exp_q.pop_back());
      void'(exp_near_q.pop_back());
      void'(exp_cyc_q.pop_back());
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_drop_cnt"}, int'(drop_cnt), mdrop);
    check({tag, "_filled"}, int'(filled), int'(mfilled));
    check({tag, "_near"}, int'(near), int'(mnear));
    check({tag, "_avg_hold"}, int'(avg_dist), mavg);
    check({tag, "_state"}, int'(dbg_state), int'(mfilled));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    dist_done = 1'b0;
    dist_in   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_avg_dist", int'(avg_dist), 0);
    check("rst_avg_valid", int'(avg_valid), 0);
    check("rst_near", int'(near), 0);
    check("rst_filled", int'(filled), 0);
    check("rst_drop_cnt", int'(drop_cnt), 0);

    // fill with 100s
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 100);
      idle(9);
    end
    check("fill_avg", int'(avg_dist), 100);
    check("fill_filled", int'(filled), 1);
    check_quiet("fill");

    // wrap-around with 200s
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 200);
      idle(5);
    end
    check("wrap_avg", int'(avg_dist), 200);

    // rejection
    step(1'b1, 0);   idle(4);
    step(1'b1, 500); idle(4);
    check("rej_drop2", int'(drop_cnt), 2);
    step(1'b1, 400); idle(4);
    check("rej_avg250", int'(avg_dist), 250);
    for (int i = 0; i < 300; i++) begin
      step(1'b1, (i % 2 == 0) ? 0 : $urandom_range(401, 1023));
    end
    idle(4);
    check("rej_drop_sat", int'(drop_cnt), 255);
    check_quiet("rej");

    // hysteresis
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 30);
      idle(3);
    end
    check("hyst_near30", int'(near), 0);
    step(1'b1, 10); idle(3);
    step(1'b1, 10); idle(3);
    check("hyst_near20", int'(near), 1);
    step(1'b1, 40); idle(3);
    check("hyst_near22", int'(near), 1);
    step(1'b1, 40); idle(3);
    check("hyst_near25", int'(near), 0);

    // reset with a sample in flight
    step(1'b1, 90);
    do_reset();
    idle(4);
    check("midrst_filled", int'(filled), 0);
    check("midrst_drop", int'(drop_cnt), 0);
    check("midrst_near", int'(near), 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 80);
      idle(2);
    end
    idle(3);
    check("midrst_avg80", int'(avg_dist), 80);

    // back-to-back strobes
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 50);
    idle(6);
    check_quiet("b2b");

    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 2) != 0) begin
        if ($urandom_range(0, 3) == 0) step(1'b1, $urandom_range(0, 1023));
        else step(1'b1, $urandom_range(1, 60));
      end else begin
        idle(1);
      end
    end
    idle(8);
    check_quiet("rand");

    check("drain_pending", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
